spell_mem_arbiter: RTL and testbench



---
 rtl/spell_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_spell_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_mem_arbiter.sv
// Two-port arbiter sharing the spell memory between the spell core (A) and the
// Wishbone bridge (B): round-robin or fixed priority, latched request, timeout.
//
// Handshake: a requester raises *_select with stable fields and holds it until
// the single-cycle *_data_ready pulse; mem_select behaves the same toward the
// memory and completes on mem_data_ready. The grant output is the FSM state
// (00 IDLE, 01 GRANT_A, 10 GRANT_B).
module spell_mem_arbiter #(
  parameter bit          FIXED_PRIORITY_A = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       a_select,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_data_in,
  input  logic [1:0] a_memory_type,
  input  logic       a_write,
  output logic       a_data_ready,
  output logic       a_timeout,
  input  logic       b_select,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_data_in,
  input  logic [1:0] b_memory_type,
  input  logic       b_write,
  output logic       b_data_ready,
  output logic       b_timeout,
  output logic [7:0] data_out,
  output logic       mem_select,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic [1:0] mem_type,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       last_b_q, last_b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [1:0] type_q, type_d;
  logic       write_q, write_d;
  logic       own_select;
  logic       done;
  logic       timed_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= 8'h00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      type_q   <= 2'b00;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    type_d       = type_q;
    write_d      = write_q;
    own_select   = 1'b0;
    done         = 1'b0;
    timed_out    = 1'b0;
    a_data_ready = 1'b0;
    a_timeout    = 1'b0;
    b_data_ready = 1'b0;
    b_timeout    = 1'b0;
    data_out     = 8'h00;
    case (state_q)
      IDLE: begin
        // A wins a tie under fixed priority or when B was served last.
        if (a_select && (!b_select || FIXED_PRIORITY_A || last_b_q)) begin
          state_d  = GRANT_A;
          last_b_d = 1'b0;
          cnt_d    = 8'h00;
          addr_d   = a_addr;
          wdata_d  = a_data_in;
          type_d   = a_memory_type;
          write_d  = a_write;
        end else if (b_select) begin
          state_d  = GRANT_B;
          last_b_d = 1'b1;
          cnt_d    = 8'h00;
          addr_d   = b_addr;
          wdata_d  = b_data_in;
          type_d   = b_memory_type;
          write_d  = b_write;
        end
      end
      GRANT_A, GRANT_B: begin
        own_select = (state_q == GRANT_A) ? a_select : b_select;
        // A dropped select abandons the access silently.
        if (!own_select) begin
          state_d = IDLE;
        end else if (mem_data_ready) begin
          done     = 1'b1;
          data_out = mem_data_out;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (state_q == GRANT_A) begin
          a_data_ready = done;
          a_timeout    = timed_out;
        end else begin
          b_data_ready = done;
          b_timeout    = timed_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_select  = (state_q != IDLE);
  assign mem_write   = write_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_type    = type_q;
  assign grant       = {state_q == GRANT_B, state_q == GRANT_A};

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench for spell_mem_arbiter: round-robin DUT plus a fixed-priority
// twin, a latency-3 memory responder and a completion/grant scoreboard.
module tb_spell_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_select, b_select, a_write, b_write;
  logic [7:0] a_addr, b_addr, a_data_in, b_data_in;
  logic [1:0] a_type, b_type;
  logic [7:0] mem_rdata;
  logic       mem_rdy;

  logic       a_ready, a_to, b_ready, b_to, mem_select, mem_write;
  logic [7:0] data_out, mem_addr, mem_wdata;
  logic [1:0] mem_type, grant;

  logic       f_a_ready, f_a_to, f_b_ready, f_b_to, f_mem_select, f_mem_write;
  logic [7:0] f_data_out, f_mem_addr, f_mem_wdata;
  logic [1:0] f_mem_type, f_grant;

  int checks = 0;
  int failures = 0;
  bit mem_en = 1'b1;
  int mem_cnt = 0;

  // {port_b, timeout, mem_addr, data_out} for each expected completion
  logic [17:0] exp_q[$];
  logic [1:0]  grant_q[$];
  logic [1:0]  prev_grant = 2'b00;

  spell_mem_arbiter #(.FIXED_PRIORITY_A(1'b0), .TIMEOUT_CYCLES(8)) dut (
    .clock(clk), .reset_n(rst_n),
    .a_select(a_select), .a_addr(a_addr), .a_data_in(a_data_in),
    .a_memory_type(a_type), .a_write(a_write),
    .a_data_ready(a_ready), .a_timeout(a_to),
    .b_select(b_select), .b_addr(b_addr), .b_data_in(b_data_in),
    .b_memory_type(b_type), .b_write(b_write),
    .b_data_ready(b_ready), .b_timeout(b_to),
    .data_out(data_out), .mem_select(mem_select), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_in(mem_wdata), .mem_type(mem_type),
    .mem_data_out(mem_rdata), .mem_data_ready(mem_rdy), .grant(grant)
  );

  spell_mem_arbiter #(.FIXED_PRIORITY_A(1'b1), .TIMEOUT_CYCLES(8)) dut_fixed (
    .clock(clk), .reset_n(rst_n),
    .a_select(a_select), .a_addr(a_addr), .a_data_in(a_data_in),
    .a_memory_type(a_type), .a_write(a_write),
    .a_data_ready(f_a_ready), .a_timeout(f_a_to),
    .b_select(b_select), .b_addr(b_addr), .b_data_in(b_data_in),
    .b_memory_type(b_type), .b_write(b_write),
    .b_data_ready(f_b_ready), .b_timeout(f_b_to),
    .data_out(f_data_out), .mem_select(f_mem_select), .mem_write(f_mem_write),
    .mem_addr(f_mem_addr), .mem_data_in(f_mem_wdata), .mem_type(f_mem_type),
    .mem_data_out(mem_rdata), .mem_data_ready(mem_rdy), .grant(f_grant)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_ready || b_ready) begin
        n = i;
        break;
      end
    end
    chk("wait_done", 32'(n != 0), 32'd1);
  endtask

  // Memory model: ready in the 4th cycle of mem_select, data = addr ^ 0xA5
  initial begin
    mem_rdy   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = mem_addr ^ 8'hA5;
      mem_rdy   = 1'b0;
      if (mem_select && mem_en) begin
        if (mem_cnt == 3) begin
          mem_rdy = 1'b1;
          mem_cnt = 0;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard: completions and grant order
  initial begin
    logic [17:0] obs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_grant = 2'b00;
      end else begin
        if (a_ready || b_ready) begin
          obs = {b_ready, (b_ready ? b_to : a_to), mem_addr, data_out};
          checks++;
          assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=%0h expected=none", obs);
          end
          if (exp_q.size() != 0) chk("sb_completion", 32'(obs), 32'(exp_q.pop_front()));
        end
        if (grant != prev_grant) begin
          if (prev_grant != 2'b00) chk("grant_gap", 32'(grant), 32'd0);
          else if (grant_q.size() != 0) chk("grant_order", 32'(grant), 32'(grant_q.pop_front()));
          else chk("grant_unexpected", 32'(grant), 32'd0);
        end
        prev_grant = grant;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    a_select = 1'b0; b_select = 1'b0; a_write = 1'b0; b_write = 1'b0;
    a_addr = 8'h00; b_addr = 8'h00; a_data_in = 8'h00; b_data_in = 8'h00;
    a_type = 2'b00; b_type = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_select", 32'(mem_select), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ready", 32'({a_ready, a_to, b_ready, b_to}), 32'd0);
    step();
    rst_n = 1'b1;

    // Single A read
    step();
    a_select = 1'b1; a_addr = 8'h12; a_type = 2'b10; a_write = 1'b0; a_data_in = 8'h33;
    grant_q.push_back(2'b01);
    exp_q.push_back({1'b0, 1'b0, 8'h12, 8'hB7});
    @(negedge clk);
    chk("pre_grant_idle", 32'(grant), 32'd0);
    @(negedge clk);
    chk("a_grant", 32'(grant), 32'd1);
    chk("a_mem_addr", 32'(mem_addr), 32'h12);
    chk("a_mem_type", 32'(mem_type), 32'd2);
    chk("a_mem_write", 32'(mem_write), 32'd0);
    wait_done(n);
    chk("a_latency", 32'(n), 32'd3);
    step();
    a_select = 1'b0;
    @(negedge clk);
    chk("a_idle_gap", 32'(mem_select), 32'd0);
    @(negedge clk);
    chk("a_no_regrant", 32'(grant), 32'd0);

    // Simultaneous requests from reset: RR gives A,B,A,B; fixed gives A always
    do_reset();
    step();
    a_select = 1'b1; a_addr = 8'h21; a_type = 2'b00;
    b_select = 1'b1; b_addr = 8'h42; b_type = 2'b11; b_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_q.push_back((k % 2 == 0) ? {1'b0, 1'b0, 8'h21, 8'h84} : {1'b1, 1'b0, 8'h42, 8'hE7});
    end
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      chk("rr_spacing", 32'(n), 32'd5);
      chk("fixed_grant", 32'(f_grant), 32'd1);
      chk("fixed_b_starved", 32'({f_a_ready, f_b_ready}), 32'b10);
    end
    step();
    a_select = 1'b0; b_select = 1'b0;
    repeat (2) step();

    // B write with A arriving mid-grant; B fields change after the grant
    b_select = 1'b1; b_addr = 8'h80; b_data_in = 8'h5A; b_write = 1'b1; b_type = 2'b01;
    grant_q.push_back(2'b10);
    exp_q.push_back({1'b1, 1'b0, 8'h80, 8'h25});
    @(negedge clk);
    @(negedge clk);
    chk("b_grant", 32'(grant), 32'd2);
    chk("b_mem_write", 32'(mem_write), 32'd1);
    chk("b_mem_wdata", 32'(mem_wdata), 32'h5A);
    chk("b_mem_addr", 32'(mem_addr), 32'h80);
    step();
    b_addr = 8'hFF; b_data_in = 8'h00; b_write = 1'b0;
    a_select = 1'b1; a_addr = 8'h07; a_write = 1'b0; a_type = 2'b11;
    grant_q.push_back(2'b01);
    exp_q.push_back({1'b0, 1'b0, 8'h07, 8'hA2});
    @(negedge clk);
    chk("b_stable", 32'({mem_write, mem_wdata, mem_addr, grant}), 32'({1'b1, 8'h5A, 8'h80, 2'b10}));
    wait_done(n);
    chk("b_latency", 32'(n), 32'd2);
    step();
    b_select = 1'b0;
    @(negedge clk);
    chk("b2a_idle", 32'(grant), 32'd0);
    @(negedge clk);
    chk("b2a_grant", 32'({grant, mem_write, mem_addr, mem_type}), 32'({2'b01, 1'b0, 8'h07, 2'b11}));
    wait_done(n);
    chk("b2a_latency", 32'(n), 32'd3);
    step();
    a_select = 1'b0;
    repeat (2) step();

    // Memory never ready: A times out, then pending B is served
    mem_en = 1'b0;
    a_select = 1'b1; a_addr = 8'h30;
    grant_q.push_back(2'b01);
    exp_q.push_back({1'b0, 1'b1, 8'h30, 8'h00});
    @(negedge clk);
    @(negedge clk);
    chk("to_grant", 32'(grant), 32'd1);
    step();
    b_select = 1'b1; b_addr = 8'h44; b_write = 1'b0; b_type = 2'b00;
    grant_q.push_back(2'b10);
    exp_q.push_back({1'b1, 1'b0, 8'h44, 8'hE1});
    wait_done(n);
    chk("to_latency", 32'(n), 32'd7);
    chk("to_flags", 32'({a_ready, a_to, b_ready, b_to, data_out}), 32'({4'b1100, 8'h00}));
    mem_en = 1'b1;
    step();
    a_select = 1'b0;
    wait_done(n);
    chk("to_then_b", 32'(n), 32'd5);
    step();
    b_select = 1'b0;
    repeat (2) step();

    // Reset mid-grant drops the access; first tie afterwards goes to A
    a_select = 1'b1; a_addr = 8'h55;
    grant_q.push_back(2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("rm_grant", 32'(grant), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async", 32'({mem_select, grant, a_ready, a_to, b_ready, b_to}), 32'd0);
    b_select = 1'b1; b_addr = 8'h66;
    repeat (2) step();
    rst_n = 1'b1;
    grant_q.push_back(2'b01);
    exp_q.push_back({1'b0, 1'b0, 8'h55, 8'hF0});
    @(negedge clk);
    @(negedge clk);
    chk("rm_tie_a", 32'(grant), 32'd1);
    wait_done(n);
    chk("rm_latency", 32'(n), 32'd3);
    step();
    a_select = 1'b0; b_select = 1'b0;
    repeat (2) step();

    // A abandons its grant; pending B follows after one idle cycle
    a_select = 1'b1; a_addr = 8'h0A;
    grant_q.push_back(2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("ab_grant", 32'(grant), 32'd1);
    step();
    b_select = 1'b1; b_addr = 8'h0B;
    grant_q.push_back(2'b10);
    exp_q.push_back({1'b1, 1'b0, 8'h0B, 8'hAE});
    step();
    a_select = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ab_abort", 32'({mem_select, grant, a_ready, a_to}), 32'd0);
    @(negedge clk);
    chk("ab_b_grant", 32'(grant), 32'd2);
    wait_done(n);
    chk("ab_b_latency", 32'(n), 32'd3);
    step();
    b_select = 1'b0;
    repeat (3) step();

    chk("sb_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_grant_empty", 32'(grant_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
